pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_src_mux.sv | 21 ++
 rtl/pc_sequencer.sv | 94 +++++++++
 tb/tb_pc_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the PC sequencer: PC-source selects and FSM state type.
package pc_sequencer_pkg;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JMP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10
    } state_t;

endpackage

// File: rtl/pc_src_mux.sv
// 3-input 32-bit PC-source multiplexer; unused select code falls back to sequential.
module pc_src_mux
    import pc_sequencer_pkg::*;
(
    input  logic [1:0]  sel_i,
    input  logic [31:0] seq_i,
    input  logic [31:0] br_i,
    input  logic [31:0] jmp_i,
    output logic [31:0] pc_o
);

    always_comb begin
        pc_o = seq_i;
        case (sel_i)
            PCSEL_BR:  pc_o = br_i;
            PCSEL_JMP: pc_o = jmp_i;
            default:   pc_o = seq_i;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer: IDLE -> FETCH -> EXEC loop with stall, branch and jump redirects.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [1:0]  pc_sel,
    output logic        instr_valid,
    output logic        align_err,
    output logic [31:0] retired_cnt
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] mux_pc;
    logic        advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect targets are word-aligned before the mux; align_err reports the raw low bits.
    pc_src_mux u_mux (
        .sel_i (pc_sel),
        .seq_i (pc_q + 32'd4),
        .br_i  ({branch_target[31:2], 2'b00}),
        .jmp_i ({jump_target[31:2], 2'b00}),
        .pc_o  (mux_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        align_err   = 1'b0;
        pc_sel      = PCSEL_SEQ;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_valid = 1'b1;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    advance = 1'b1;
                    if (jump) begin
                        pc_sel    = PCSEL_JMP;
                        align_err = |jump_target[1:0];
                    end else if (branch_taken) begin
                        pc_sel    = PCSEL_BR;
                        align_err = |branch_target[1:0];
                    end
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            pc_d  = mux_pc;
            cnt_d = cnt_q + 32'd1;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-step bench for pc_sequencer; hand-computed expectations checked with immediate assertions.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] pc;
    logic [1:0]  pc_sel;
    logic        instr_valid;
    logic        align_err;
    logic [31:0] retired_cnt;

    int vectors = 0;
    int miscompares = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .pc            (pc),
        .pc_sel        (pc_sel),
        .instr_valid   (instr_valid),
        .align_err     (align_err),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full cycle: through the rising edge, land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0; imem_ready = 1'b1;
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_cnt", retired_cnt, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_ivalid", {31'b0, instr_valid}, 32'h0);
        check("rst_aerr", {31'b0, align_err}, 32'h0);
        check("rst_pcsel", {30'b0, pc_sel}, 32'h0);
        tick(); tick();
        check("rst_hold_req", {31'b0, imem_req}, 32'h0);

        // Release: IDLE first, late ready must not produce a fetch pulse
        rst_n = 1'b1; #1;
        check("idle_ivalid", {31'b0, instr_valid}, 32'h0);
        check("idle_req", {31'b0, imem_req}, 32'h0);

        // Sequential run with ready tied high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_fetch_req", {31'b0, imem_req}, 32'h1);
            check("seq_fetch_ivalid", {31'b0, instr_valid}, 32'h1);
            check("seq_fetch_addr", imem_addr, 32'(i * 4));
            tick();
            check("seq_exec_pc", pc, 32'(i * 4));
            check("seq_exec_pcsel", {30'b0, pc_sel}, 32'h0);
            check("seq_exec_req", {31'b0, imem_req}, 32'h0);
        end
        tick();
        check("seq_pc_c", pc, 32'hC);
        check("seq_cnt3", retired_cnt, 32'd3);

        // Fetch held off by imem_ready low for three cycles
        imem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {31'b0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'hC);
            check("wait_ivalid", {31'b0, instr_valid}, 32'h0);
            tick();
        end
        imem_ready = 1'b1; #1;
        check("ready_ivalid", {31'b0, instr_valid}, 32'h1);
        tick();

        // Jump beats branch, no alignment error
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_target = 32'h200; #1;
        check("both_pcsel", {30'b0, pc_sel}, 32'h2);
        check("both_aerr", {31'b0, align_err}, 32'h0);
        tick();
        branch_taken = 1'b0; jump = 1'b0;
        check("both_pc", pc, 32'h200);
        check("both_cnt", retired_cnt, 32'd4);
        tick();

        // Stall four cycles in EXEC, then misaligned taken branch
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h103; #1;
        for (int i = 0; i < 4; i++) begin
            check("stall_pc", pc, 32'h200);
            check("stall_cnt", retired_cnt, 32'd4);
            check("stall_pcsel", {30'b0, pc_sel}, 32'h0);
            check("stall_aerr", {31'b0, align_err}, 32'h0);
            check("stall_req", {31'b0, imem_req}, 32'h0);
            tick();
        end
        stall = 1'b0; #1;
        check("br_pcsel", {30'b0, pc_sel}, 32'h1);
        check("br_aerr", {31'b0, align_err}, 32'h1);
        tick();
        branch_taken = 1'b0;
        check("br_pc", pc, 32'h100);
        check("br_aerr_gone", {31'b0, align_err}, 32'h0);
        check("br_cnt", retired_cnt, 32'd5);
        tick();

        // Misaligned jump, then sequential wrap from FFFFFFFC
        jump = 1'b1; jump_target = 32'hFFFF_FFFE; #1;
        check("jmp_aerr", {31'b0, align_err}, 32'h1);
        tick();
        jump = 1'b0;
        check("jmp_pc", pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pcsel", {30'b0, pc_sel}, 32'h0);
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_cnt", retired_cnt, 32'd7);
        tick();

        // Reset while a fetch is outstanding
        jump = 1'b1; jump_target = 32'h40;
        tick();
        jump = 1'b0; imem_ready = 1'b0; #1;
        check("pre_rst_pc", pc, 32'h40);
        check("pre_rst_req", {31'b0, imem_req}, 32'h1);
        #1 rst_n = 1'b0; #1;
        check("midrst_req", {31'b0, imem_req}, 32'h0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_cnt", retired_cnt, 32'h0);
        imem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; #1;
        check("late_ready_ivalid", {31'b0, instr_valid}, 32'h0);
        tick();
        check("refetch_addr", imem_addr, 32'h0);
        check("refetch_ivalid", {31'b0, instr_valid}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
